// File: rtl/arrow_sprite_renderer.sv
// Arrow sprite renderer.
// Draws a SIZE x SIZE bitmap sprite at a position supplied by the dropper. It
// also runs a small score FSM that flashes a highlight for FLASH_FRAMES frames
// and counts hits. The position and bitmap are latched once per frame at
// frame_start, so a mid-frame update from the dropper never tears the image.
// Pixel path: shadows -> stage 1 (box test, relative coords) -> stage 2
// (bitmap lookup). is_arrow therefore lags DrawX/DrawY by two clocks.

module arrow_sprite_renderer #(
    parameter int SIZE         = 40,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [9:0]             dropX,
    input  logic [9:0]             dropY,
    input  logic [SIZE*SIZE-1:0]   arrow,
    input  logic                   score,
    output logic                   is_arrow,
    output logic                   flash_on,
    output logic [7:0]             hits
);

    localparam int IDX_W = $clog2(SIZE * SIZE);
    localparam int REL_W = $clog2(SIZE);
    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FLASH,
        HOLD
    } score_state_t;

    // Frame-stable copies of the dropper's position and bitmap.
    logic [9:0]           sh_x;
    logic [9:0]           sh_y;
    logic [SIZE*SIZE-1:0] sh_arrow;

    // Stage 1 combinational results and their registers.
    logic             in_box_c;
    logic [REL_W-1:0] rel_x_c;
    logic [REL_W-1:0] rel_y_c;
    logic             in_box_d;
    logic [REL_W-1:0] rel_x_d;
    logic [REL_W-1:0] rel_y_d;

    // Bitmap index for stage 2.
    logic [IDX_W-1:0] pix_idx;

    // Score FSM state.
    score_state_t     state;
    logic [CNT_W-1:0] flash_cnt;

    // Latch the sprite position and bitmap once per frame, at vertical blank.
    // NOTE: every clocked register uses non-blocking assignments. Stage 1
    // below then sees the pre-update shadows in the load cycle, which is what
    // keeps the pixel sampled in that cycle on the old frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_arrow <= '0;
        end else if (frame_start) begin
            sh_x     <= dropX;
            sh_y     <= dropY;
            sh_arrow <= arrow;
        end
    end

    // Box test done at 11 bits so that sh_x + SIZE can never wrap past 1023.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        in_box_c = ({1'b0, DrawX} >= {1'b0, sh_x}) &&
                   ({1'b0, DrawX} <  ({1'b0, sh_x} + 11'(SIZE))) &&
                   ({1'b0, DrawY} >= {1'b0, sh_y}) &&
                   ({1'b0, DrawY} <  ({1'b0, sh_y} + 11'(SIZE)));
        rel_x_c = '0;
        rel_y_c = '0;
        // Relative coordinates are kept only inside the box. This bounds the
        // stage-2 index to the bitmap (max SIZE*SIZE-1).
        if (in_box_c) begin
            rel_x_c = REL_W'(DrawX - sh_x);
            rel_y_c = REL_W'(DrawY - sh_y);
        end
    end

    // Stage 1 register: box hit and sprite-relative coordinates.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            in_box_d <= 1'b0;
            rel_x_d  <= '0;
            rel_y_d  <= '0;
        end else begin
            in_box_d <= in_box_c;
            rel_x_d  <= rel_x_c;
            rel_y_d  <= rel_y_c;
        end
    end

    // Row-major bitmap index: row * SIZE + col.
    assign pix_idx = IDX_W'(rel_y_d) * IDX_W'(SIZE) + IDX_W'(rel_x_d);

    // Stage 2 register: look up the bitmap bit for in-box pixels.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_arrow <= 1'b0;
        end else begin
            is_arrow <= in_box_d & sh_arrow[pix_idx];
        end
    end

    // Score FSM: count a hit once per rising score level, flash for
    // FLASH_FRAMES frames, then hold until score falls. flash_on is
    // registered together with the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            flash_cnt <= '0;
            flash_on  <= 1'b0;
            hits      <= '0;
        end else if (frame_start) begin
            case (state)
                IDLE: begin
                    if (score) begin
                        state     <= FLASH;
                        flash_on  <= 1'b1;
                        flash_cnt <= CNT_W'(FLASH_FRAMES - 1);
                        hits      <= (hits == 8'hFF) ? hits : hits + 8'd1;
                    end
                end
                FLASH: begin
                    // score is ignored here, so the flash always runs its full length.
                    if (flash_cnt == '0) begin
                        state    <= HOLD;
                        flash_on <= 1'b0;
                    end else begin
                        flash_cnt <= flash_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!score) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    flash_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arrow_sprite_renderer.sv
// Self-checking bench for arrow_sprite_renderer.
// A behavioural model keeps the per-frame sprite position and bitmap. It
// answers "is this pixel a set sprite bit?" with plain integer arithmetic.
// A frame-level model tracks flash frames remaining and hit count.

module tb_arrow_sprite_renderer;

    localparam int SIZE = 40;
    localparam int FF   = 8;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 frame_start;
    logic [9:0]           DrawX, DrawY, dropX, dropY;
    logic [SIZE*SIZE-1:0] arrow;
    logic                 score;
    logic                 is_arrow, flash_on;
    logic [7:0]           hits;

    arrow_sprite_renderer #(.SIZE(SIZE), .FLASH_FRAMES(FF)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .dropX      (dropX),
        .dropY      (dropY),
        .arrow      (arrow),
        .score      (score),
        .is_arrow   (is_arrow),
        .flash_on   (flash_on),
        .hits       (hits)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int                   m_x, m_y;
    logic [SIZE*SIZE-1:0] m_bmp;
    int                   m_hits;
    int                   m_flash_left;   // flash frames still to show
    bit                   m_holding;      // hit counted, waiting for score low
    bit                   exp_q[$];       // expected is_arrow, oldest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_pixel(input int x, input int y);
        if (x >= m_x && x < m_x + SIZE && y >= m_y && y < m_y + SIZE)
            return m_bmp[(y - m_y) * SIZE + (x - m_x)];
        return 1'b0;
    endfunction

    // Drive one pixel per clock. The result for the pixel from two clocks
    // earlier is checked first.
    task automatic step_pixel(input int x, input int y, input string tag);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 2) check(tag, is_arrow, exp_q.pop_front());
        DrawX = 10'(x);
        DrawY = 10'(y);
        exp_q.push_back(exp_pixel(x, y));
    endtask

    task automatic flush(input string tag);
        while (exp_q.size() > 0) begin
            @(posedge Clk);
            #1;
            check(tag, is_arrow, exp_q.pop_front());
        end
    endtask

    // One frame_start pulse with the given score. The model is advanced and
    // the FSM outputs are checked.
    task automatic frame(input bit sc);
        @(posedge Clk);
        #1;
        score       = sc;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        m_x   = int'(dropX);
        m_y   = int'(dropY);
        m_bmp = arrow;
        if (m_flash_left > 0) begin
            m_flash_left--;
        end else if (m_holding) begin
            if (!sc) m_holding = 1'b0;
        end else if (sc) begin
            if (m_hits < 255) m_hits++;
            m_flash_left = FF;
            m_holding    = 1'b1;
        end
        check("flash_on", flash_on, 32'(m_flash_left > 0));
        check("hits", hits, 32'(m_hits));
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_bmp = '0;
        m_hits = 0; m_flash_left = 0; m_holding = 1'b0;
        exp_q.delete();
    endtask

    task automatic rand_bitmap();
        for (int i = 0; i < SIZE * SIZE / 32; i++) arrow[i*32 +: 32] = $urandom();
    endtask

    int flash_frames;
    int x, y;

    initial begin
        Reset = 1'b1; frame_start = 1'b0; score = 1'b0;
        DrawX = '0; DrawY = '0; dropX = '0; dropY = '0; arrow = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_is_arrow", is_arrow, 0);
        check("rst_flash_on", flash_on, 0);
        check("rst_hits", hits, 0);
        Reset = 1'b0;

        // Single bit 420 (row 10, col 20) at (160,100): only pixel (180,110) lights.
        dropX = 10'd160; dropY = 10'd100;
        arrow = '0; arrow[420] = 1'b1;
        frame(1'b0);
        for (int yy = 95; yy <= 145; yy++)
            for (int xx = 150; xx <= 210; xx++) step_pixel(xx, yy, "sweep");
        flush("sweep");

        // Corners and box edges.
        arrow[0] = 1'b1; arrow[1599] = 1'b1;
        frame(1'b0);
        step_pixel(199, 139, "corner_br");
        step_pixel(200, 139, "right_edge");
        step_pixel(159, 100, "left_edge");
        step_pixel(160, 100, "corner_tl");
        step_pixel(199, 140, "bottom_edge");
        step_pixel(180, 110, "bit420");
        flush("edges");

        // dropY moves mid-frame; no change until the next frame_start.
        dropY = 10'd101;
        step_pixel(180, 110, "no_tear");
        step_pixel(180, 111, "no_tear");
        flush("no_tear");
        frame(1'b0);
        step_pixel(180, 111, "shifted");
        step_pixel(180, 110, "shifted");
        step_pixel(160, 101, "shifted");
        flush("shifted");

        // Random positions and bitmaps; the first pass uses an all-zero bitmap.
        for (int n = 0; n < 20; n++) begin
            dropX = 10'($urandom_range(1023));
            dropY = 10'($urandom_range(1023));
            if (n == 0) arrow = '0; else rand_bitmap();
            frame(1'b0);
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(2) != 0) begin
                    x = m_x - 5 + $urandom_range(49);
                    y = m_y - 5 + $urandom_range(49);
                end else begin
                    x = $urandom_range(1023);
                    y = $urandom_range(1023);
                end
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                step_pixel(x, y, "rand_pix");
            end
            flush("rand_pix");
        end

        // Score held high for 20 frames: one hit, exactly FF flash frames.
        flash_frames = 0;
        for (int f = 0; f < 20; f++) begin
            frame(1'b1);
            if (flash_on) flash_frames++;
        end
        check("flash_len", flash_frames, FF);
        check("held_hits", hits, 1);
        frame(1'b0);
        frame(1'b1);
        check("second_hit", hits, 2);

        // Random score, including drops mid-flash.
        for (int f = 0; f < 80; f++) frame(1'(($urandom_range(1)) != 0));

        // Saturate the hit counter, then one more hit.
        for (int f = 0; f < 20000 && m_hits < 255; f++) frame(1'($urandom_range(3) != 0));
        check("pre_sat", hits, 255);
        while (m_flash_left > 0 || m_holding) frame(1'b0);
        flash_frames = 0;
        frame(1'b1);
        if (flash_on) flash_frames++;
        for (int f = 0; f < 12; f++) begin
            frame(1'b1);
            if (flash_on) flash_frames++;
        end
        check("sat_hits", hits, 255);
        check("sat_flash_len", flash_frames, FF);
        while (m_holding) frame(1'b0);

        // Reset mid-flash with the sprite on screen.
        dropX = 10'd300; dropY = 10'd200;
        arrow = '1;
        frame(1'b1);
        for (int k = 0; k < 10; k++) step_pixel(310 + k, 210, "pre_rst");
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("rst_now_is_arrow", is_arrow, 0);
        check("rst_now_flash_on", flash_on, 0);
        check("rst_now_hits", hits, 0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 10; k++) step_pixel(310 + k, 210, "post_rst");
        flush("post_rst");
        check("post_rst_flash", flash_on, 0);
        frame(1'b0);
        for (int k = 0; k < 10; k++) step_pixel(310 + k, 210 + k, "reloaded");
        step_pixel(340, 210, "reloaded_out");
        flush("reloaded");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arrow_sprite_renderer.md
ARROW_SPRITE_RENDERER -- requirements
Module: arrow_sprite_renderer

Interface
REQ-001 SHALL have parameter SIZE, default 40, sprite edge length in pixels.
REQ-002 SHALL have parameter FLASH_FRAMES, default 8, frames the hit flash is shown.
REQ-003 SHALL have port Clk, input, 1, pixel clock; all logic on posedge Clk.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port frame_start, input, 1, one-cycle pulse marking start of vertical blank.
REQ-006 SHALL have ports DrawX and DrawY, input, 10 each, current pixel coordinates.
REQ-007 SHALL have ports dropX and dropY, input, 10 each, sprite top-left from the dropper.
REQ-008 SHALL have port arrow, input, 1600, sprite bitmap, row-major: bit index = row*40 + col, row 0 at top.
REQ-009 SHALL have port score, input, 1, level hit flag from the dropper.
REQ-010 SHALL have port is_arrow, output, 1, current pixel belongs to the sprite.
REQ-011 SHALL have port flash_on, output, 1, hit-flash highlight active.
REQ-012 SHALL have port hits, output, 8, saturating count of scored hits.

Function
REQ-013 SHALL hold shadow copies of dropX, dropY and arrow, loaded only in the cycle frame_start=1; rendering uses shadows only (no tearing).
REQ-014 SHALL treat a shadow load in cycle N as visible to pixels sampled in cycle N+1 onward; the pixel sampled in cycle N uses old shadows.
REQ-015 Stage 1 SHALL register in_box = (DrawX >= shX) & (DrawX < shX+SIZE) & (DrawY >= shY) & (DrawY < shY+SIZE), sums computed 11-bit (no wrap), plus relX = DrawX-shX, relY = DrawY-shY.
REQ-016 Stage 2 SHALL register is_arrow = in_box_d & shadow_arrow[relY*40 + relX], index computed 11-bit (max 1599).
REQ-017 is_arrow SHALL lag DrawX/DrawY by exactly 2 Clk cycles.
REQ-018 An all-zero bitmap (dropper finished state) SHALL yield is_arrow=0 everywhere.
REQ-019 Score FSM SHALL have states IDLE, FLASH, HOLD; score sampled only in frame_start cycles.
REQ-020 IDLE: frame_start & score=1 -> FLASH, flash_cnt <= FLASH_FRAMES-1, hits <= hits+1 saturating at 255.
REQ-021 FLASH: flash_on=1; each frame_start decrements flash_cnt; frame_start with flash_cnt=0 -> HOLD.
REQ-022 HOLD: flash_on=0; frame_start & score=0 -> IDLE; score staying high SHALL NOT recount.
REQ-023 flash_on SHALL be 1 exactly in FLASH, registered (changes the cycle after the transition edge).
REQ-024 score dropping to 0 during FLASH SHALL NOT shorten the flash; FLASH always lasts FLASH_FRAMES frame_start pulses.
REQ-025 hits at 255 SHALL stay 255 on further hits while FSM still transitions.

Reset
REQ-026 Reset=1 SHALL immediately clear shadows, pipeline registers, flash_cnt, hits; FSM -> IDLE; is_arrow=0, flash_on=0, hits=0.
REQ-027 Reset asserted mid-frame or mid-flash SHALL abort; no shadow reload until next frame_start after release.

Verification
REQ-028 Load dropX=160, dropY=100, arrow bit 420 only; frame_start; sweep DrawX/DrawY -> is_arrow=1 only for pixel (180,110), 2 cycles after it is driven.
REQ-029 Same load, drive (199,139) and (200,139) -> is_arrow from bitmap bit 1599 then 0; (159,100) -> 0.
REQ-030 Change dropY to 101 mid-frame without frame_start -> output unchanged until next frame_start, then sprite shifts down one row.
REQ-031 score=1 at one frame_start, held 20 frames -> hits=1, flash_on high for exactly 8 frames, then HOLD; score low at a frame_start then high again -> hits=2.
REQ-032 Preload 255 hits via 255 score pulses, one more pulse -> hits stays 255, flash_on still asserted 8 frames.
REQ-033 Reset pulse during FLASH with sprite on screen -> is_arrow, flash_on, hits all 0 immediately; no sprite until next frame_start.
